// File: rtl/vga_pkg.sv
// Shared types and default timing constants for the VGA framebuffer scheduler.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned RGB565_W       = 16;
    localparam int unsigned H_VISIBLE      = 640;
    localparam int unsigned V_VISIBLE      = 480;
    localparam int unsigned DEF_RD_LAT     = 2;
    localparam int unsigned DEF_HOST_RATIO = 4;

    typedef logic [RGB565_W-1:0] pix_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vga_rd_tracker.sv
// Tracks fetch reads in flight through the fixed-latency RAM; the tail bit marks
// the cycle the read data is present on mem_rdata.
module vga_rd_tracker #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic squash,
    output logic tail_valid
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;

    always_comb begin
        valid_d = '0;
        if (!squash) begin
            valid_d[0] = issue;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign tail_valid = valid_q[RD_LAT-1];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single-port framebuffer RAM between line prefetch into the
// ping-pong line buffer and host pixel writes.
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned HWIDTH     = H_VISIBLE,
    parameter int unsigned VWIDTH     = V_VISIBLE,
    parameter int unsigned PIX_W      = RGB565_W,
    parameter int unsigned RD_LAT     = DEF_RD_LAT,
    parameter int unsigned HOST_RATIO = DEF_HOST_RATIO,
    parameter int unsigned ADDR_W     = $clog2(HWIDTH * VWIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        line_req,
    input  logic [$clog2(VWIDTH)-1:0]   line_y,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [PIX_W-1:0]            host_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [PIX_W-1:0]            mem_wdata,
    input  logic [PIX_W-1:0]            mem_rdata,
    output logic                        lb_we,
    output logic                        lb_wbank,
    output logic [$clog2(HWIDTH)-1:0]   lb_waddr,
    output logic [PIX_W-1:0]            lb_wdata,
    output logic                        line_done,
    output logic                        underrun,
    input  logic                        underrun_clr
);

    localparam int unsigned X_W = $clog2(HWIDTH);
    localparam int unsigned S_W = cnt_w(HOST_RATIO);
    localparam logic [X_W-1:0] LAST_X   = X_W'(HWIDTH - 1);
    localparam logic [S_W-1:0] SLOT_MAX = S_W'(HOST_RATIO);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [X_W-1:0]    rd_x_q, rd_x_d;
    logic [X_W-1:0]    wr_x_q, wr_x_d;
    logic [S_W-1:0]    slot_q, slot_d;
    logic              bank_q, bank_d;
    logic              underrun_q, underrun_d;

    logic rd_issue;
    logic squash;
    logic tail_valid;

    vga_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .issue      (rd_issue),
        .squash     (squash),
        .tail_valid (tail_valid)
    );

    // Next state, RAM arbitration and line-buffer fill.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rd_x_d     = rd_x_q;
        wr_x_d     = wr_x_q;
        slot_d     = slot_q;
        bank_d     = bank_q;
        underrun_d = underrun_q;
        host_ready = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        lb_we      = 1'b0;
        lb_waddr   = '0;
        lb_wdata   = '0;
        line_done  = 1'b0;
        squash     = 1'b0;
        rd_issue   = 1'b0;

        case (state_q)
            FETCH: begin
                if (host_valid && (slot_q == SLOT_MAX)) begin
                    host_ready = 1'b1;
                    slot_d     = '0;
                end else if (!line_req) begin
                    // No read in a restart cycle: it would belong to the aborted line.
                    rd_issue = 1'b1;
                    rd_x_d   = rd_x_q + 1'b1;
                    if (slot_q != SLOT_MAX) begin
                        slot_d = slot_q + 1'b1;
                    end
                    if (rd_x_q == LAST_X) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: begin
                host_ready = host_valid;
            end
        endcase

        if (host_ready) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = host_addr;
            mem_wdata = host_data;
        end else if (rd_issue) begin
            mem_req  = 1'b1;
            mem_addr = base_q + ADDR_W'(rd_x_q);
        end

        if (tail_valid && !line_req) begin
            lb_we    = 1'b1;
            lb_waddr = wr_x_q;
            lb_wdata = mem_rdata;
            wr_x_d   = wr_x_q + 1'b1;
            if ((state_q == DRAIN) && (wr_x_q == LAST_X)) begin
                line_done = 1'b1;
                state_d   = IDLE;
                wr_x_d    = '0;
            end
        end

        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        if (line_req) begin
            if (state_q != IDLE) begin
                squash     = 1'b1;
                underrun_d = 1'b1;
            end
            state_d = FETCH;
            base_d  = ADDR_W'(line_y) * ADDR_W'(HWIDTH);
            rd_x_d  = '0;
            wr_x_d  = '0;
            slot_d  = '0;
            bank_d  = ~bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            rd_x_q     <= '0;
            wr_x_q     <= '0;
            slot_q     <= '0;
            bank_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rd_x_q     <= rd_x_d;
            wr_x_q     <= wr_x_d;
            slot_q     <= slot_d;
            bank_q     <= bank_d;
            underrun_q <= underrun_d;
        end
    end

    assign lb_wbank = bank_q;
    assign underrun = underrun_q;

    line_y_legal: assert property (@(posedge clk) disable iff (rst)
        line_req |-> (32'(line_y) < VWIDTH));

endmodule
